audio2eth_interleaved_packetizer_mc: RTL and testbench
======================================================

# audio2eth_interleaved_packetizer_mc

Parametrised multichannel successor to the audio-to-Ethernet interleaved packetizer. It accepts one parallel audio frame per handshake (all `NUM_CH` channels at once) and serialises the frames into channel-interleaved 32-bit words. The output is framed into packets: a header word, `frames_per_pkt` interleaved frames, then `m_axis_tlast` on the final word. It sits between the I2S/audio capture front end and the Ethernet/UDP framer, and is configured by the AXI4-Lite register slave.

## Interface
Parameters:
- `NUM_CH`, 2 — channels per frame, 1..16.
- `SAMPLE_W`, 24 — bits per sample, 8..32.
- `MAX_FRAMES`, 256 — upper clamp for `frames_per_pkt`, 1..65535.

Ports:
- `ACLK` in 1 — single clock; all logic is on the rising edge.
- `ARESET` in 1 — reset, synchronous and active-high.
- `en` in 1 — packetizer enable; sampled only in IDLE.
- `frames_per_pkt` in 16 — frames per packet; latched at packet start.
- `s_axis_tdata` in NUM_CH*SAMPLE_W — one frame; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- `s_axis_tvalid` in 1 — frame valid.
- `s_axis_tready` out 1 — frame accepted when high together with valid.
- `m_axis_tdata` out 32 — header or sample word.
- `m_axis_tvalid` out 1 — output word valid.
- `m_axis_tready` in 1 — downstream ready.
- `m_axis_tlast` out 1 — last word of packet.
- `busy` out 1 — high in any state other than IDLE.
- `pkt_seq` out 16 — sequence number of the next packet to be emitted.

## Operation
States: IDLE, HDR, TS (present only with the macro), WAIT, SER.

- **IDLE**
  - `s_axis_tready`=0, `m_axis_tvalid`=0.
  - If `en`=1: latch `nframes` = `frames_per_pkt`, clamped so that 0→1 and values above MAX_FRAMES become MAX_FRAMES; clear the frame counter; go to HDR.
- **HDR**
  - `m_axis_tvalid`=1, `m_axis_tdata` = {`pkt_seq`, `nframes`}.
  - On handshake: go to TS if compiled in, else WAIT.
- **WAIT**
  - `s_axis_tready`=1, `m_axis_tvalid`=0.
  - On input handshake: capture the frame into a shadow register, set channel index `ch`=0, go to SER.
- **SER**
  - `m_axis_tvalid`=1, `m_axis_tdata` = sign-extension of shadow channel `ch` to 32 bits. When SAMPLE_W=32 the sample passes through unchanged.
  - On handshake with `ch` < NUM_CH-1: increment `ch`.
  - On handshake with `ch` = NUM_CH-1 and frame counter = `nframes`-1: this beat carries `m_axis_tlast`=1; increment `pkt_seq`; go to IDLE.
  - On handshake with `ch` = NUM_CH-1 otherwise: increment the frame counter; go to WAIT.

Rules:
- `m_axis_tlast` is high only on the final SER beat of a packet.
- `pkt_seq` wraps from 0xFFFF to 0x0000.
- Deasserting `en` mid-packet has no effect; the packet completes and the block then stays in IDLE.
- Changing `frames_per_pkt` mid-packet has no effect until the next IDLE→HDR transition.
- `s_axis_tready` is low in every state except WAIT. Upstream must buffer or drop frames; this block never drops.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata` and `m_axis_tlast` hold stable.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `pkt_seq`=0. Frame counter, `ch` and timestamp counter are 0. State is IDLE.
- Reset mid-packet: all of the above take effect on the next edge; the partial packet is abandoned with no `m_axis_tlast`.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE with `en`=1 at edge N: header is valid from cycle N+1.
- Frame accepted at edge N: channel 0 word is valid from cycle N+1.
- Steady-state cost with `m_axis_tready`=1: NUM_CH+1 cycles per frame (1 WAIT + NUM_CH SER).
- Steady-state cost per packet: 1 IDLE + 1 HDR (+1 TS) cycles on top of the frame cost.

## Configuration
- `PKT_TIMESTAMP_EN` defined:
  - Adds state TS between HDR and WAIT, emitting one word: a 32-bit count of all frames accepted since reset.
  - The count increments on every input handshake and wraps at 2^32.
  - The TS word carries the count value at packet start, before that packet's first frame is accepted.
- `PKT_TIMESTAMP_EN` undefined: no TS state and no counter; HDR goes directly to WAIT.

## Test plan
- **Basic packet.** NUM_CH=2, SAMPLE_W=24, `frames_per_pkt`=4, `m_axis_tready`=1, frames {0x000002,0x000001}…
  - → 9 words: 0x00000004, then 0x00000001, 0x00000002, …
  - → `m_axis_tlast` only on word 9; `pkt_seq` becomes 1.
  - → second packet header = 0x00010004.
- **Sign extension.** Channel 0 = 0x800001, channel 1 = 0x7FFFFF → 0xFF800001, 0x007FFFFF.
- **Clamp.** `frames_per_pkt`=0 → header 0x00000001, 3 words total, tlast on word 3.
- **Clamp, upper.** `frames_per_pkt`=0x1000 with MAX_FRAMES=256 → header low half = 0x0100.
- **Backpressure.** Hold `m_axis_tready`=0 for 5 cycles mid-SER → data and tlast stable; `s_axis_tready`=0 throughout; no words lost or duplicated.
- **Reset and en.**
  - `ARESET`=1 for 1 cycle after word 3 → all outputs at reset values next cycle; next packet header = 0x00000004 (`pkt_seq`=0).
  - `en` dropped during SER → current packet completes with tlast, then `busy`=0.
- **Timestamp.** With `PKT_TIMESTAMP_EN`, 2 packets of 4 frames → TS words 0x00000000 and 0x00000004.

Source files
------------

// File: rtl/audio2eth_interleaved_packetizer_mc.sv
// ---------------------------------------------------------------------------
// audio2eth_interleaved_packetizer_mc
//
// Accepts one parallel multichannel audio frame per input handshake and
// serialises it into channel-interleaved, sign-extended 32-bit words.
// Words are grouped into packets:
//   header {pkt_seq, nframes}, [timestamp], nframes * NUM_CH samples.
// m_axis_tlast marks the last sample word of each packet.
//
// Optional feature macro: PKT_TIMESTAMP_EN
//   When defined, a timestamp word (32-bit count of all frames accepted
//   since reset, sampled at packet start) follows the header.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   en                    start a new packet (sampled only while idle)
//   frames_per_pkt        frames per packet, latched at packet start
//   s_axis_*              input frame stream (channel k at [k*SAMPLE_W +: SAMPLE_W])
//   m_axis_*              output word stream with tlast
//   busy                  high whenever a packet is in progress
//   pkt_seq               sequence number of the next packet to be emitted
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. Once m_axis_tvalid is raised it stays
// high, with m_axis_tdata/m_axis_tlast unchanged, until the transfer occurs.
// All outputs come straight from flops; every *_d value is computed from the
// next state so outputs are valid in the cycle the state is entered.
// ---------------------------------------------------------------------------
module audio2eth_interleaved_packetizer_mc #(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 24,
    parameter int MAX_FRAMES = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         en,
    input  logic [15:0]                  frames_per_pkt,
    input  logic [NUM_CH*SAMPLE_W-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [31:0]                  m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic [15:0]                  pkt_seq
);

    localparam int                FRAME_W = NUM_CH * SAMPLE_W;
    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0]       MAX_F16 = 16'(MAX_FRAMES);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

`ifdef PKT_TIMESTAMP_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TS   = 3'd2,
        ST_WAIT = 3'd3,
        ST_SER  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_WAIT = 3'd3,
        ST_SER  = 3'd4
    } state_t;
`endif

    state_t               state_q,   state_d;
    logic [15:0]          nframes_q, nframes_d;
    logic [15:0]          fcnt_q,    fcnt_d;
    logic [CH_W-1:0]      ch_q,      ch_d;
    logic [FRAME_W-1:0]   shadow_q,  shadow_d;
    logic [15:0]          seq_q,     seq_d;
    logic [31:0]          tdata_q,   tdata_d;
    logic                 tvalid_q,  tvalid_d;
    logic                 tlast_q,   tlast_d;
    logic                 tready_q,  tready_d;
    logic                 busy_q,    busy_d;
`ifdef PKT_TIMESTAMP_EN
    logic [31:0]          ts_q,      ts_d;
`endif

    logic                 m_hs;
    logic                 s_hs;
    logic signed [SAMPLE_W-1:0] sample_s;

    // Transfers are judged on the registered valid/ready we are presenting.
    assign m_hs = tvalid_q & m_axis_tready;
    assign s_hs = tready_q & s_axis_tvalid;

    always_comb begin
        state_d   = state_q;
        nframes_d = nframes_q;
        fcnt_d    = fcnt_q;
        ch_d      = ch_q;
        shadow_d  = shadow_q;
        seq_d     = seq_q;
`ifdef PKT_TIMESTAMP_EN
        ts_d      = s_hs ? ts_q + 32'd1 : ts_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (frames_per_pkt == 16'd0) begin
                        nframes_d = 16'd1;
                    end else if (frames_per_pkt > MAX_F16) begin
                        nframes_d = MAX_F16;
                    end else begin
                        nframes_d = frames_per_pkt;
                    end
                    fcnt_d  = 16'd0;
                    ch_d    = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_hs) begin
`ifdef PKT_TIMESTAMP_EN
                    state_d = ST_TS;
`else
                    state_d = ST_WAIT;
`endif
                end
            end
`ifdef PKT_TIMESTAMP_EN
            ST_TS: begin
                if (m_hs) begin
                    state_d = ST_WAIT;
                end
            end
`endif
            ST_WAIT: begin
                if (s_hs) begin
                    shadow_d = s_axis_tdata;
                    ch_d     = '0;
                    state_d  = ST_SER;
                end
            end
            ST_SER: begin
                if (m_hs) begin
                    if (ch_q != LAST_CH) begin
                        ch_d = ch_q + CH_W'(1);
                    end else if (fcnt_q == nframes_q - 16'd1) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = ST_IDLE;
                    end else begin
                        fcnt_d  = fcnt_q + 16'd1;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flops are loaded from the next-state view.
        sample_s = shadow_d[int'(ch_d) * SAMPLE_W +: SAMPLE_W];
        tvalid_d = 1'b0;
        tdata_d  = 32'd0;
        tready_d = (state_d == ST_WAIT);
        busy_d   = (state_d != ST_IDLE);
        tlast_d  = (state_d == ST_SER) && (ch_d == LAST_CH) &&
                   (fcnt_d == nframes_d - 16'd1);
        case (state_d)
            ST_HDR: begin
                tvalid_d = 1'b1;
                tdata_d  = {seq_d, nframes_d};
            end
`ifdef PKT_TIMESTAMP_EN
            ST_TS: begin
                tvalid_d = 1'b1;
                tdata_d  = ts_d;
            end
`endif
            ST_SER: begin
                tvalid_d = 1'b1;
                // Signed size cast sign-extends; identity when SAMPLE_W is 32.
                tdata_d  = 32'(sample_s);
            end
            default: begin
                tvalid_d = 1'b0;
                tdata_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            nframes_q <= 16'd0;
            fcnt_q    <= 16'd0;
            ch_q      <= '0;
            shadow_q  <= '0;
            seq_q     <= 16'd0;
            tdata_q   <= 32'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tready_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PKT_TIMESTAMP_EN
            ts_q      <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            nframes_q <= nframes_d;
            fcnt_q    <= fcnt_d;
            ch_q      <= ch_d;
            shadow_q  <= shadow_d;
            seq_q     <= seq_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tready_q  <= tready_d;
            busy_q    <= busy_d;
`ifdef PKT_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign pkt_seq       = seq_q;

endmodule

// File: tb/tb_audio2eth_interleaved_packetizer_mc.sv
// ---------------------------------------------------------------------------
// Self-checking bench for audio2eth_interleaved_packetizer_mc.
// A reference model turns each packet request into the expected word list
// (header, optional timestamp, sign-extended samples, tlast on the last one);
// a single cycle loop drives both streams and scores every output transfer.
// ---------------------------------------------------------------------------
module tb_audio2eth_interleaved_packetizer_mc;

    localparam int NUM_CH     = 2;
    localparam int SAMPLE_W   = 24;
    localparam int MAX_FRAMES = 256;
    localparam int FRAME_W    = NUM_CH * SAMPLE_W;
`ifdef PKT_TIMESTAMP_EN
    localparam int TSW = 1;
`else
    localparam int TSW = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               ACLK = 1'b0;
    logic               ARESET;
    logic               en;
    logic [15:0]        frames_per_pkt;
    logic [FRAME_W-1:0] s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               busy;
    logic [15:0]        pkt_seq;

    always #5 ACLK = ~ACLK;

    audio2eth_interleaved_packetizer_mc #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .MAX_FRAMES(MAX_FRAMES)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .en(en), .frames_per_pkt(frames_per_pkt),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .pkt_seq(pkt_seq)
    );

    // ---------------- scoreboard state ----------------
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [32:0]        exp_q[$];   // {tlast, word}
    int                 kind_q[$];  // 0 header, 1 timestamp, 2 sample
    logic [FRAME_W-1:0] frm_q[$];   // frames waiting to be offered
    logic [FRAME_W-1:0] fix_q[$];   // optional fixed frame pattern
    logic [31:0]        cap_q[$];   // words captured in the last run
    logic [15:0]        model_seq = 16'd0;
    logic [31:0]        model_ts  = 32'd0;

    // ---------------- reference model ----------------
    function automatic logic [15:0] clamp_frames(input logic [15:0] f);
        if (f == 16'd0) return 16'd1;
        if (int'(f) > MAX_FRAMES) return 16'(MAX_FRAMES);
        return f;
    endfunction

    task automatic build_model(input int npkts, input logic [15:0] fpp);
        logic [15:0]        nf;
        logic [FRAME_W-1:0] frame;
        logic [SAMPLE_W-1:0] smp;
        int                 sx;
        logic [31:0]        w;
        logic               last;
        for (int p = 0; p < npkts; p++) begin
            nf = clamp_frames(fpp);
            exp_q.push_back({1'b0, model_seq, nf});
            kind_q.push_back(0);
            model_seq = model_seq + 16'd1;
`ifdef PKT_TIMESTAMP_EN
            exp_q.push_back({1'b0, model_ts});
            kind_q.push_back(1);
`endif
            for (int f = 0; f < int'(nf); f++) begin
                if (fix_q.size() > 0) begin
                    frame = fix_q[f % fix_q.size()];
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        case ($urandom_range(0, 3))
                            0: smp = {1'b1, {(SAMPLE_W-1){1'b0}}};
                            1: smp = {1'b0, {(SAMPLE_W-1){1'b1}}};
                            default: smp = SAMPLE_W'($urandom);
                        endcase
                        frame[c*SAMPLE_W +: SAMPLE_W] = smp;
                    end
                end
                frm_q.push_back(frame);
                for (int c = 0; c < NUM_CH; c++) begin
                    smp = frame[c*SAMPLE_W +: SAMPLE_W];
                    sx  = int'(smp);
                    if (sx >= (1 << (SAMPLE_W - 1))) sx = sx - (1 << SAMPLE_W);
                    w    = sx;
                    last = (f == int'(nf) - 1) && (c == NUM_CH - 1);
                    exp_q.push_back({last, w});
                    kind_q.push_back(2);
                end
            end
            model_ts = model_ts + 32'(nf);
        end
    endtask

    // ---------------- driver + checker loop ----------------
    // Inputs are changed on the falling edge; the transfer decided there
    // takes place on the following rising edge.
    task automatic run(input int npkts, input logic [15:0] fpp,
                       input int vprob, input int rprob, input int abort_after);
        int          hdrs;
        int          budget;
        int          kind;
        logic        prev_stall;
        logic [32:0] prev_word;
        logic [32:0] exp_w;
        logic [32:0] got_w;
        logic        aborted;
        hdrs       = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        aborted    = 1'b0;
        cap_q.delete();
        build_model(npkts, fpp);
        budget = 200 + 20 * exp_q.size();
        frames_per_pkt = fpp;
        en = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge ACLK);
            budget--;
            if (abort_after > 0 && cap_q.size() == abort_after) begin
                m_axis_tready = 1'b0;
                s_axis_tvalid = 1'b0;
                en            = 1'b0;
                aborted       = 1'b1;
                break;
            end
            if (prev_stall) begin
                n_checks++;
                if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, prev_word}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b last=%0b data=%08h, need valid=1 last=%0b data=%08h",
                             m_axis_tvalid, m_axis_tlast, m_axis_tdata, prev_word[32], prev_word[31:0]);
                end
            end
            n_checks++;
            if (s_axis_tready && m_axis_tvalid) begin
                n_fail++;
                $display("FAIL ready_overlap: s_axis_tready=1 with m_axis_tvalid=1, need never both");
            end
            m_axis_tready = ($urandom_range(0, 99) < rprob);
            s_axis_tvalid = (frm_q.size() > 0) && ($urandom_range(0, 99) < vprob);
            s_axis_tdata  = (frm_q.size() > 0) ? frm_q[0] : '0;
            if (m_axis_tvalid && m_axis_tready) begin
                exp_w = exp_q.pop_front();
                kind  = kind_q.pop_front();
                got_w = {m_axis_tlast, m_axis_tdata};
                n_checks++;
                if (got_w !== exp_w) begin
                    n_fail++;
                    $display("FAIL word[%0d]: got last=%0b data=%08h, need last=%0b data=%08h",
                             cap_q.size(), got_w[32], got_w[31:0], exp_w[32], exp_w[31:0]);
                end
                cap_q.push_back(m_axis_tdata);
                if (kind == 0) begin
                    hdrs++;
                    if (hdrs == npkts) en = 1'b0;
                    frames_per_pkt = 16'($urandom);  // must not affect this packet
                end
                if (exp_w[32]) frames_per_pkt = fpp;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tdata};
            if (s_axis_tready && s_axis_tvalid) void'(frm_q.pop_front());
        end
        if (aborted) begin
            exp_q.delete();
            kind_q.delete();
            frm_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: %0d words still outstanding, need 0", exp_q.size());
                exp_q.delete();
                kind_q.delete();
                frm_q.delete();
                en = 1'b0;
            end
            @(negedge ACLK);
            s_axis_tvalid = 1'b0;
            repeat (3) @(negedge ACLK);
            n_checks++;
            if ({busy, m_axis_tvalid, pkt_seq} !== {1'b0, 1'b0, model_seq}) begin
                n_fail++;
                $display("FAIL post_packet: got busy=%0b valid=%0b pkt_seq=%04h, need busy=0 valid=0 pkt_seq=%04h",
                         busy, m_axis_tvalid, pkt_seq, model_seq);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        en     = 1'b0;
        @(negedge ACLK);
        ARESET    = 1'b0;
        model_seq = 16'd0;
        model_ts  = 32'd0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, pkt_seq} !== '0) begin
            n_fail++;
            $display("FAIL %s: got tready=%0b tvalid=%0b tlast=%0b tdata=%08h busy=%0b pkt_seq=%04h, need all 0",
                     name, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, pkt_seq);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESET = 1'b1;
        en = 1'b0;
        frames_per_pkt = 16'd4;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge ACLK);
        check_reset_outputs("reset_values");
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        check_reset_outputs("idle_without_en");
    endtask

    task automatic test_basic();
        logic [FRAME_W-1:0] fr;
        fr = {24'h000002, 24'h000001};
        fix_q.delete();
        fix_q.push_back(fr);
        run(1, 16'd4, 100, 100, 0);
        n_checks++;
        if (cap_q.size() != 9 + TSW || cap_q[0] !== 32'h00000004 ||
            cap_q[1+TSW] !== 32'h1 || cap_q[2+TSW] !== 32'h2) begin
            n_fail++;
            $display("FAIL basic_packet: got %0d words first=%08h, need %0d words first=00000004 then 1,2",
                     cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 32'h0, 9 + TSW);
        end
        run(1, 16'd4, 100, 100, 0);
        n_checks++;
        if (cap_q[0] !== 32'h00010004) begin
            n_fail++;
            $display("FAIL second_header: got %08h, need 00010004", cap_q[0]);
        end
        fix_q.delete();
    endtask

    task automatic test_sign_ext();
        logic [FRAME_W-1:0] fr;
        fr = {24'h7FFFFF, 24'h800001};
        fix_q.delete();
        fix_q.push_back(fr);
        run(1, 16'd1, 100, 100, 0);
        n_checks++;
        if (cap_q[1+TSW] !== 32'hFF800001 || cap_q[2+TSW] !== 32'h007FFFFF) begin
            n_fail++;
            $display("FAIL sign_ext: got %08h %08h, need FF800001 007FFFFF",
                     cap_q[1+TSW], cap_q[2+TSW]);
        end
        fix_q.delete();
    endtask

    task automatic test_clamp();
        logic [31:0] hdr;
        run(1, 16'd0, 100, 100, 0);
        hdr = cap_q[0];
        n_checks++;
        if (cap_q.size() != 3 + TSW || hdr[15:0] !== 16'h0001) begin
            n_fail++;
            $display("FAIL clamp_zero: got %0d words header=%08h, need %0d words low half 0001",
                     cap_q.size(), hdr, 3 + TSW);
        end
        run(1, 16'h1000, 100, 100, 0);
        hdr = cap_q[0];
        n_checks++;
        if (hdr[15:0] !== 16'h0100) begin
            n_fail++;
            $display("FAIL clamp_upper: got header=%08h, need low half 0100", hdr);
        end
    endtask

    task automatic test_backpressure();
        run(3, 16'd5, 60, 30, 0);
        run(2, 16'($urandom_range(1, 8)), 90, 50, 0);
    endtask

    task automatic test_reset_mid();
        run(1, 16'd4, 100, 100, 3);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("reset_mid_packet");
        ARESET    = 1'b0;
        model_seq = 16'd0;
        model_ts  = 32'd0;
        run(1, 16'd4, 100, 100, 0);
        n_checks++;
        if (cap_q[0] !== 32'h00000004) begin
            n_fail++;
            $display("FAIL header_after_reset: got %08h, need 00000004", cap_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        run(4, 16'd3, 100, 100, 0);
        run(3, 16'($urandom_range(0, 6)), 80, 80, 0);
    endtask

`ifdef PKT_TIMESTAMP_EN
    task automatic test_timestamp();
        apply_reset();
        run(2, 16'd4, 100, 100, 0);
        n_checks++;
        if (cap_q[1] !== 32'h0 || cap_q[11] !== 32'h4) begin
            n_fail++;
            $display("FAIL timestamp: got %08h %08h, need 00000000 00000004", cap_q[1], cap_q[11]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sign_ext();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef PKT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
